// File: rtl/mips_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_pkg : constants shared by the fetch pipeline (reset PC, NOP, width)  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;
endpackage : mips_pkg

`default_nettype wire

// File: rtl/if_id_reg.sv
// +--------------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with load, bubble and hold controls   |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [31:0]        pc4In,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc4,
  output logic               valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc4;
  logic               r_valid;

  // Bubble wins over load; with neither asserted the register holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= PC_RESET;
      r_valid <= 1'b0;
    end else if (bubble) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= pc4In;
      r_valid <= 1'b0;
    end else if (load) begin
      r_instr <= instrIn;
      r_pc4   <= pc4In;
      r_valid <= 1'b1;
    end
  end

  assign instr = r_instr;
  assign pc4   = r_pc4;
  assign valid = r_valid;

endmodule : if_id_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage : PC register, next-PC mux, stall counter and IF/ID register. |
// | Define FETCH_DELAY_SLOT_EN to let the instruction after a branch execute. |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               is_pause,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [15:0]        stall_count
);

  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_pcNext;
  logic [15:0] r_stallCount;
  logic        w_ifIdLoad;
  logic        w_ifIdBubble;

  assign w_pc4     = r_pc + PC_STEP;
  assign imem_addr = r_pc;

  // A pause freezes everything, including any redirect raised alongside it.
  always_comb begin
    w_pcNext = w_pc4;
    if (is_pause) begin
      w_pcNext = r_pc;
    end else if (redirect) begin
      w_pcNext = {redirect_pc[31:2], 2'b00};
    end
  end

`ifdef FETCH_DELAY_SLOT_EN
  assign w_ifIdLoad   = !is_pause;
  assign w_ifIdBubble = 1'b0;
`else
  assign w_ifIdLoad   = !is_pause && !redirect;
  assign w_ifIdBubble = !is_pause && redirect;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_pcNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCount <= 16'd0;
    end else if (is_pause && (r_stallCount != STALL_MAX)) begin
      r_stallCount <= r_stallCount + 16'd1;
    end
  end

  assign stall_count = r_stallCount;

  if_id_reg u_ifIdReg (
    .clk     (clk),
    .reset   (reset),
    .load    (w_ifIdLoad),
    .bubble  (w_ifIdBubble),
    .instrIn (imem_rdata),
    .pc4In   (w_pc4),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

endmodule : fetch_stage

`default_nettype wire
